ifetch_responder: RTL and testbench

IFETCH_RESPONDER -- requirements
Module: ifetch_responder

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch_responder.sv | 141 ++++++++++++++
 tb/tb_ifetch_responder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch responder: FSM states and line geometry.
package ifetch_pkg;

  localparam int unsigned LINE_OFF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    RESP     = 2'd3
  } state_e;

endpackage

// File: rtl/ifetch_responder.sv
// Single-outstanding line fetch: accept -> mem req -> wait -> done (min 3 cycles), stalls on mem_req_ready;
// flush kills in-flight fetches. IFETCH_RESP_PERF_EN adds fetch/drop counters.
module ifetch_responder
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pc_index_valid,
  input  logic [ADDR_W-1:0] pc_index,
  output logic              pc_index_ready,
  output logic              pc_operation_done,
  output logic [DATA_W-1:0] pc_read_inst,
  input  logic              flush_valid,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data
`ifdef IFETCH_RESP_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);

  state_e            state_q, state_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              fetch_evt, drop_evt;
  logic              unused_line_off;

  assign unused_line_off = ^pc_index[LINE_OFF-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    fetch_evt = 1'b0;
    drop_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pc_index_valid && pc_index_ready) begin
          addr_d  = {pc_index[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        // A flush racing the handshake still owes us a response, so wait and discard it.
        if (mem_req_ready) begin
          state_d = MEM_WAIT;
          drop_d  = flush_valid;
        end else if (flush_valid) begin
          state_d  = IDLE;
          drop_evt = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
          if (drop_q || flush_valid) begin
            drop_d   = 1'b0;
            drop_evt = 1'b1;
          end else begin
            inst_d  = mem_rsp_data;
            state_d = RESP;
          end
        end else if (flush_valid) begin
          drop_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (flush_valid) drop_evt = 1'b1;
        else             fetch_evt = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so nothing looks acceptable while the block is held in reset.
  always_comb begin
    pc_index_ready    = 1'b0;
    mem_req_valid     = 1'b0;
    pc_operation_done = 1'b0;
    case (state_q)
      IDLE:    pc_index_ready    = reset_n && !flush_valid;
      MEM_REQ: mem_req_valid     = 1'b1;
      RESP:    pc_operation_done = !flush_valid;
      default: ;
    endcase
  end

  assign mem_req_addr = addr_q;
  assign pc_read_inst = inst_q;

`ifdef IFETCH_RESP_PERF_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [31:0] perf_drop_cnt_q, perf_drop_cnt_d;

  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q + {31'd0, fetch_evt};
    perf_drop_cnt_d  = perf_drop_cnt_q + {31'd0, drop_evt};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetch_cnt_q <= '0;
      perf_drop_cnt_q  <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_drop_cnt_q  <= perf_drop_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_drop_cnt  = perf_drop_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = fetch_evt ^ drop_evt;
`endif

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed + randomized bench for ifetch_responder against a transaction-level fetch model.
module tb_ifetch_responder;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 128;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              pc_index_valid = 1'b0;
  logic [ADDR_W-1:0] pc_index = '0;
  logic              pc_index_ready;
  logic              pc_operation_done;
  logic [DATA_W-1:0] pc_read_inst;
  logic              flush_valid = 1'b0;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid = 1'b0;
  logic [DATA_W-1:0] mem_rsp_data = '0;

  ifetch_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .pc_index_valid    (pc_index_valid),
    .pc_index          (pc_index),
    .pc_index_ready    (pc_index_ready),
    .pc_operation_done (pc_operation_done),
    .pc_read_inst      (pc_read_inst),
    .flush_valid       (flush_valid),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_rsp_valid     (mem_rsp_valid),
    .mem_rsp_data      (mem_rsp_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int seen_done = 0;
  logic [DATA_W-1:0] exp_inst = '0;

  always @(negedge clock) if (reset_n && pc_operation_done) seen_done++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Noise on inputs that must not matter while the block is busy.
  task automatic drive_busy();
    pc_index_valid = 1'($urandom_range(0, 1));
    pc_index       = {$urandom, $urandom};
    mem_rsp_valid  = 1'($urandom_range(0, 1));
    mem_rsp_data   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // fl_state: 0 none, 1 flush in MEM_REQ at offset fl_off, 2 flush in MEM_WAIT at fl_off, 3 flush in RESP.
  task automatic run_fetch(input logic [63:0] pc, input int req_wait, input int rsp_wait,
                           input int fl_state, input int fl_off);
    logic [63:0] al;
    bit          dropped;
    bit          killed;
    al      = {pc[63:4], 4'h0};
    dropped = 1'b0;
    killed  = 1'b0;

    @(posedge clock); #1;
    pc_index_valid = 1'b1; pc_index = pc;
    flush_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clock);
    chk("acc_ready", pc_index_ready, 1);
    chk("acc_inst", pc_read_inst, exp_inst);

    for (int k = 0; k <= req_wait && !killed; k++) begin
      @(posedge clock); #1;
      drive_busy();
      mem_req_ready = (k == req_wait);
      flush_valid   = (fl_state == 1 && k == fl_off);
      @(negedge clock);
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_req_addr, al);
      chk("req_busy_ready", pc_index_ready, 0);
      chk("req_done", pc_operation_done, 0);
      if (flush_valid && !mem_req_ready) killed = 1'b1;
      else if (flush_valid) dropped = 1'b1;
    end

    if (!killed) begin
      for (int k = 0; k <= rsp_wait; k++) begin
        @(posedge clock); #1;
        drive_busy();
        mem_req_ready = 1'($urandom_range(0, 1));
        flush_valid   = (fl_state == 2 && k == fl_off);
        mem_rsp_valid = (k == rsp_wait);
        mem_rsp_data  = {al, $urandom, $urandom};
        @(negedge clock);
        chk("wait_req_valid", mem_req_valid, 0);
        chk("wait_ready", pc_index_ready, 0);
        chk("wait_done", pc_operation_done, 0);
        if (flush_valid) dropped = 1'b1;
        if (mem_rsp_valid && !dropped) exp_inst = mem_rsp_data;
      end
      if (!dropped) begin
        @(posedge clock); #1;
        drive_busy();
        mem_req_ready = 1'b0;
        flush_valid   = (fl_state == 3);
        @(negedge clock);
        chk("resp_done", pc_operation_done, !flush_valid);
        chk("resp_inst", pc_read_inst, exp_inst);
        chk("resp_ready", pc_index_ready, 0);
        if (!flush_valid) exp_done++;
      end
    end

    // Back in IDLE; a stray memory response here must be ignored.
    @(posedge clock); #1;
    pc_index_valid = 1'b0; flush_valid = 1'b0;
    mem_req_ready = 1'($urandom_range(0, 1));
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clock);
    chk("idle_ready", pc_index_ready, 1);
    chk("idle_done", pc_operation_done, 0);
    chk("idle_req_valid", mem_req_valid, 0);
    chk("idle_inst", pc_read_inst, exp_inst);
  endtask

  initial begin
    int rw, sw, fs, fo;

    pc_index_valid = 1'b1;
    pc_index = 64'h8000_0004;
    #12;
    chk("rst_ready", pc_index_ready, 0);
    chk("rst_done", pc_operation_done, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_inst", pc_read_inst, 0);
    chk("rst_addr", mem_req_addr, 0);
    @(negedge clock);
    pc_index_valid = 1'b0;
    reset_n = 1'b1;

    run_fetch(64'h8000_0004, 0, 0, 0, 0);
    run_fetch(64'h8000_0044, 5, 2, 0, 0);
    run_fetch(64'h8000_0080, 0, 4, 2, 0);
    run_fetch(64'h8000_00C0, 3, 0, 1, 1);
    run_fetch(64'h8000_0010, 0, 0, 0, 0);
    run_fetch(64'h8000_0000, 1, 1, 0, 0);
    run_fetch(64'h8000_0010, 0, 2, 0, 0);
    run_fetch(64'h8000_0100, 2, 1, 1, 2);
    run_fetch(64'h8000_0140, 0, 3, 2, 3);
    run_fetch(64'h8000_0180, 1, 0, 3, 0);

    for (int i = 0; i < 40; i++) begin
      rw = $urandom_range(0, 4);
      sw = $urandom_range(0, 4);
      fs = $urandom_range(0, 3);
      fo = (fs == 1) ? $urandom_range(0, rw) : $urandom_range(0, sw + 1);
      run_fetch({$urandom, $urandom}, rw, sw, fs, fo);
    end

    // Reset while waiting on memory abandons the fetch.
    @(posedge clock); #1;
    pc_index_valid = 1'b1; pc_index = 64'h8000_0020; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    @(posedge clock); #1;
    pc_index_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clock); #1;
    mem_req_ready = 1'b0;
    @(negedge clock);
    chk("mw_req_valid", mem_req_valid, 0);
    chk("mw_ready", pc_index_ready, 0);
    reset_n = 1'b0;
    #1;
    exp_inst = '0;
    chk("mw_rst_ready", pc_index_ready, 0);
    chk("mw_rst_done", pc_operation_done, 0);
    chk("mw_rst_req_valid", mem_req_valid, 0);
    chk("mw_rst_inst", pc_read_inst, 0);
    chk("mw_rst_addr", mem_req_addr, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", pc_index_ready, 1);
    chk("post_rst_done", pc_operation_done, 0);
    run_fetch(64'h8000_0010, 0, 0, 0, 0);

    chk("done_count", seen_done, exp_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
